// File: rtl/test_tone_gen.sv
// -----------------------------------------------------------------------------
// test_tone_gen
//   Stereo test-signal source for the effect chain. Produces triangle,
//   sawtooth or square waves (or silence) as signed {lc, rc} frames, one frame
//   per programmable sample tick, with runtime amplitude, step, rate and
//   right-channel mode.
//
// Parameters
//   W       sample width per channel
//   DIV_W   width of the sample-rate divider
//
// Ports
//   clk      system clock
//   rst      synchronous reset, active-low
//   en       1 = run, 0 = freeze all state (no new strobes)
//   mode     0 off, 1 triangle, 2 sawtooth, 3 square
//   rc_mode  0 rc=lc, 1 rc=-lc, 2 rc=0, 3 rc=lc of the previous strobe
//   amp      unsigned peak, saturated to 2^(W-1)-1
//   step     tri/saw: increment per sample; square: half-period in samples
//   div      one sample every div+1 clock cycles
//   data_o   {lc, rc}, both signed W bits, held between strobes
//   vld_o    one-cycle strobe marking a new data_o
// -----------------------------------------------------------------------------
module test_tone_gen #(
    parameter int W     = 16,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [1:0]       rc_mode,
    input  logic [W-1:0]     amp,
    input  logic [W-1:0]     step,
    input  logic [DIV_W-1:0] div,
    output logic [2*W-1:0]   data_o,
    output logic             vld_o
);

    typedef enum logic [1:0] {
        MODE_OFF = 2'd0,
        MODE_TRI = 2'd1,
        MODE_SAW = 2'd2,
        MODE_SQR = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        RC_COPY  = 2'd0,
        RC_NEG   = 2'd1,
        RC_ZERO  = 2'd2,
        RC_DELAY = 2'd3
    } rc_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Two guard bits: |acc| <= 2^(W-1)-1 and step <= 2^W-1, so acc +/- step
    // always fits without wrapping.
    localparam int SW = W + 2;
    localparam logic [W-1:0] AMAX = {1'b0, {(W-1){1'b1}}};

    // State
    logic [DIV_W-1:0]    tick_cnt;
    logic signed [W-1:0] acc;
    dir_e                dir;
    logic [W-1:0]        sq_cnt;
    logic                sq_pol;      // 1 = positive half
    mode_e               mode_q;      // mode seen on the last tick
    logic [W-1:0]        prev_lc;     // lc of the last strobe, for rc delay

    // Tick and effective current state
    logic                tick;
    mode_e               mode_in;
    rc_e                 rc_in;
    logic                mode_chg;
    dir_e                dir_cur;
    logic [W-1:0]        sq_cnt_cur;
    logic                sq_pol_cur;

    // Arithmetic
    logic [W-1:0]         a_u;
    logic signed [SW-1:0] a_s;
    logic signed [SW-1:0] neg_a;
    logic signed [SW-1:0] acc_x;
    logic signed [SW-1:0] acc_c;
    logic signed [SW-1:0] step_s;
    logic signed [SW-1:0] n_up;
    logic signed [SW-1:0] n_dn;
    logic [W-1:0]         sq_lim;

    // Next values, committed on a tick
    logic [W-1:0]        acc_nx;
    dir_e                dir_nx;
    logic [W-1:0]        sq_cnt_nx;
    logic                sq_pol_nx;
    logic [W-1:0]        lc_nx;
    logic [W-1:0]        rc_nx;

    // >= rather than == so a div lowered below the running count fires at once.
    assign tick    = en && (tick_cnt >= div);
    assign mode_in = mode_e'(mode);
    assign rc_in   = rc_e'(rc_mode);

    // A mode change restarts direction and square phase before this tick's
    // sample is computed.
    assign mode_chg   = (mode_in != mode_q);
    assign dir_cur    = mode_chg ? DIR_UP : dir;
    assign sq_cnt_cur = mode_chg ? '0 : sq_cnt;
    assign sq_pol_cur = mode_chg ? 1'b1 : sq_pol;

    assign a_u    = (amp > AMAX) ? AMAX : amp;
    assign a_s    = $signed({2'b00, a_u});
    assign neg_a  = -a_s;
    assign acc_x  = $signed({{2{acc[W-1]}}, acc});
    assign acc_c  = (acc_x > a_s) ? a_s : ((acc_x < neg_a) ? neg_a : acc_x);
    assign step_s = $signed({2'b00, step});
    assign n_up   = acc_c + step_s;
    assign n_dn   = acc_c - step_s;
    assign sq_lim = (step == '0) ? '0 : (step - W'(1));

    always_comb begin
        acc_nx    = acc;
        dir_nx    = dir_cur;
        sq_cnt_nx = sq_cnt_cur;
        sq_pol_nx = sq_pol_cur;
        lc_nx     = '0;
        unique case (mode_in)
            MODE_OFF: begin
                lc_nx = '0;
            end
            MODE_TRI: begin
                if (dir_cur == DIR_UP) begin
                    if (n_up >= a_s) begin
                        acc_nx = a_s[W-1:0];
                        dir_nx = DIR_DOWN;
                    end else begin
                        acc_nx = n_up[W-1:0];
                    end
                end else begin
                    if (n_dn <= neg_a) begin
                        acc_nx = neg_a[W-1:0];
                        dir_nx = DIR_UP;
                    end else begin
                        acc_nx = n_dn[W-1:0];
                    end
                end
                lc_nx = acc_nx;
            end
            MODE_SAW: begin
                if (n_up > a_s)
                    acc_nx = neg_a[W-1:0];
                else
                    acc_nx = n_up[W-1:0];
                lc_nx = acc_nx;
            end
            MODE_SQR: begin
                acc_nx = acc_c[W-1:0];
                lc_nx  = sq_pol_cur ? a_s[W-1:0] : neg_a[W-1:0];
                if (sq_cnt_cur >= sq_lim) begin
                    sq_cnt_nx = '0;
                    sq_pol_nx = ~sq_pol_cur;
                end else begin
                    sq_cnt_nx = sq_cnt_cur + W'(1);
                end
            end
            default: lc_nx = '0;
        endcase
    end

    always_comb begin
        rc_nx = '0;
        unique case (rc_in)
            RC_COPY:  rc_nx = lc_nx;
            RC_NEG:   rc_nx = -lc_nx;
            RC_ZERO:  rc_nx = '0;
            RC_DELAY: rc_nx = prev_lc;
            default:  rc_nx = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_cnt <= '0;
            acc      <= '0;
            dir      <= DIR_UP;
            sq_cnt   <= '0;
            sq_pol   <= 1'b1;
            mode_q   <= MODE_OFF;
            prev_lc  <= '0;
            data_o   <= '0;
            vld_o    <= 1'b0;
        end else begin
            vld_o <= tick;
            if (en)
                tick_cnt <= tick ? '0 : (tick_cnt + DIV_W'(1));
            if (tick) begin
                acc     <= acc_nx;
                dir     <= dir_nx;
                sq_cnt  <= sq_cnt_nx;
                sq_pol  <= sq_pol_nx;
                mode_q  <= mode_in;
                prev_lc <= lc_nx;
                data_o  <= {lc_nx, rc_nx};
            end
        end
    end

endmodule

// File: tb/tb_test_tone_gen.sv
module tb_test_tone_gen;

    localparam int W     = 16;
    localparam int DIV_W = 16;
    localparam int AMAXI = (1 << (W - 1)) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [1:0]       mode;
    logic [1:0]       rc_mode;
    logic [W-1:0]     amp;
    logic [W-1:0]     step;
    logic [DIV_W-1:0] div;
    logic [2*W-1:0]   data_o;
    logic             vld_o;

    int tests = 0;
    int fails = 0;

    test_tone_gen #(.W(W), .DIV_W(DIV_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .rc_mode (rc_mode),
        .amp     (amp),
        .step    (step),
        .div     (div),
        .data_o  (data_o),
        .vld_o   (vld_o)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural reference (integer arithmetic) -------------
    int             m_tc, m_acc, m_cnt, m_prev, m_last;
    bit             m_up, m_pol;
    logic           e_vld;
    logic [2*W-1:0] e_data;

    task automatic model_edge();
        int  a, lc, rc, n, lim;
        bit  tk;
        if (!rst) begin
            m_tc = 0; m_acc = 0; m_up = 1; m_cnt = 0; m_pol = 1;
            m_prev = 0; m_last = 0; e_vld = 1'b0; e_data = '0;
            return;
        end
        tk    = en && (m_tc >= int'(div));
        e_vld = tk;
        if (en) m_tc = tk ? 0 : m_tc + 1;
        if (!tk) return;
        a = (int'(amp) > AMAXI) ? AMAXI : int'(amp);
        if (int'(mode) != m_last) begin
            m_up = 1; m_cnt = 0; m_pol = 1; m_last = int'(mode);
        end
        if (mode != 2'd0) begin
            if (m_acc > a)  m_acc = a;
            if (m_acc < -a) m_acc = -a;
        end
        lc = 0;
        case (mode)
            2'd1: begin
                if (m_up) begin
                    n = m_acc + int'(step);
                    if (n >= a) begin m_acc = a; m_up = 0; end
                    else m_acc = n;
                end else begin
                    n = m_acc - int'(step);
                    if (n <= -a) begin m_acc = -a; m_up = 1; end
                    else m_acc = n;
                end
                lc = m_acc;
            end
            2'd2: begin
                n = m_acc + int'(step);
                m_acc = (n > a) ? -a : n;
                lc = m_acc;
            end
            2'd3: begin
                lc  = m_pol ? a : -a;
                lim = (step == 0) ? 0 : int'(step) - 1;
                if (m_cnt >= lim) begin m_cnt = 0; m_pol = !m_pol; end
                else m_cnt = m_cnt + 1;
            end
            default: lc = 0;
        endcase
        case (rc_mode)
            2'd0: rc = lc;
            2'd1: rc = -lc;
            2'd2: rc = 0;
            default: rc = m_prev;
        endcase
        m_prev = lc;
        e_data = {W'(lc), W'(rc)};
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    function automatic int lc_of(input logic [2*W-1:0] d);
        return int'($signed(d[2*W-1:W]));
    endfunction

    function automatic int rc_of(input logic [2*W-1:0] d);
        return int'($signed(d[W-1:0]));
    endfunction

    // One clock: reference advances at the edge, DUT compared 1 time unit later.
    task automatic step_cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("cyc_vld", 64'(vld_o), 64'(e_vld));
        check("cyc_data", 64'(data_o), 64'(e_data));
    endtask

    task automatic wait_strobe(input string name);
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step_cycle();
            if (vld_o === 1'b1) seen = 1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s: no strobe within 200 cycles, got vld 0, expected 1", name);
        end
    endtask

    task automatic wait_lc(input string name, input int target);
        bit seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            step_cycle();
            if (vld_o === 1'b1 && lc_of(data_o) == target) seen = 1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s: lc %0d not reached within 3000 cycles, got %0d", name, target, lc_of(data_o));
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step_cycle();
        rst = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0] md;
        int         am;
        int         st;
        int         dv;
        logic [1:0] rm;
        int         lc [6];
    } vec_t;

    vec_t vecs [8];

    task automatic set_vec(input int i, input logic [1:0] md, input int am, input int st,
                           input int dv, input logic [1:0] rm,
                           input int l0, input int l1, input int l2,
                           input int l3, input int l4, input int l5);
        vecs[i].md = md; vecs[i].am = am; vecs[i].st = st;
        vecs[i].dv = dv; vecs[i].rm = rm;
        vecs[i].lc[0] = l0; vecs[i].lc[1] = l1; vecs[i].lc[2] = l2;
        vecs[i].lc[3] = l3; vecs[i].lc[4] = l4; vecs[i].lc[5] = l5;
    endtask

    logic [2*W-1:0] held;

    initial begin
        int exp_rc, prev_exp;

        rst = 1'b0; en = 1'b0; mode = 2'd0; rc_mode = 2'd0;
        amp = '0; step = '0; div = '0;
        m_tc = 0; m_acc = 0; m_cnt = 0; m_prev = 0; m_last = 0;
        m_up = 1; m_pol = 1; e_vld = 1'b0; e_data = '0;

        step_cycle();
        step_cycle();
        check("reset_vld", 64'(vld_o), 64'd0);
        check("reset_data", 64'(data_o), 64'd0);

        set_vec(0, 2'd1,   200,     1, 0, 2'd1,     1,     2,     3,     4,      5,      6);
        set_vec(1, 2'd2,   100,    30, 0, 2'd0,    30,    60,    90,  -100,    -70,    -40);
        set_vec(2, 2'd3,  1000,     3, 1, 2'd2,  1000,  1000,  1000, -1000,  -1000,  -1000);
        set_vec(3, 2'd1, 65535, 20000, 0, 2'd1, 20000, 32767, 12767, -7233, -27233, -32767);
        set_vec(4, 2'd2,     0,     5, 0, 2'd1,     0,     0,     0,     0,      0,      0);
        set_vec(5, 2'd1,     3,     0, 2, 2'd3,     0,     0,     0,     0,      0,      0);
        set_vec(6, 2'd3,     5,     0, 0, 2'd3,     5,    -5,     5,    -5,      5,     -5);
        set_vec(7, 2'd0,   100,     7, 0, 2'd1,     0,     0,     0,     0,      0,      0);

        for (int v = 0; v < 8; v++) begin
            mode = vecs[v].md; amp = W'(vecs[v].am); step = W'(vecs[v].st);
            div = DIV_W'(vecs[v].dv); rc_mode = vecs[v].rm; en = 1'b1;
            do_reset();
            prev_exp = 0;
            for (int k = 0; k < 6; k++) begin
                wait_strobe($sformatf("vec%0d_strobe%0d", v, k));
                check($sformatf("vec%0d_lc%0d", v, k), 64'(lc_of(data_o)), 64'(vecs[v].lc[k]));
                case (vecs[v].rm)
                    2'd0: exp_rc = vecs[v].lc[k];
                    2'd1: exp_rc = -vecs[v].lc[k];
                    2'd2: exp_rc = 0;
                    default: exp_rc = prev_exp;
                endcase
                check($sformatf("vec%0d_rc%0d", v, k), 64'(rc_of(data_o)), 64'(exp_rc));
                prev_exp = vecs[v].lc[k];
            end
        end

        // Freeze mid-triangle, resume without a skipped value.
        mode = 2'd1; amp = W'(200); step = W'(1); div = '0; rc_mode = 2'd1; en = 1'b1;
        do_reset();
        wait_lc("freeze_reach50", 50);
        held = data_o;
        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step_cycle();
            check("freeze_vld", 64'(vld_o), 64'd0);
            check("freeze_data", 64'(data_o), 64'(held));
        end
        en = 1'b1;
        wait_strobe("resume_strobe");
        check("resume_lc", 64'(lc_of(data_o)), 64'(51));

        // Reset mid-operation.
        wait_lc("reach150", 150);
        rst = 1'b0;
        step_cycle();
        check("midrst_data", 64'(data_o), 64'd0);
        check("midrst_vld", 64'(vld_o), 64'd0);
        rst = 1'b1;
        wait_strobe("restart_strobe");
        check("restart_lc", 64'(lc_of(data_o)), 64'(1));

        // Amplitude lowered at lc=180 clamps on the next tick.
        wait_lc("reach180", 180);
        amp = W'(50);
        wait_strobe("clamp_strobe");
        check("clamp_lc", 64'(lc_of(data_o)), 64'(50));
        wait_strobe("clamp_strobe2");
        check("clamp_lc2", 64'(lc_of(data_o)), 64'(49));

        // div lowered below the running count fires on the next cycle.
        amp = W'(200); div = DIV_W'(10);
        do_reset();
        wait_strobe("div_strobe");
        for (int i = 0; i < 5; i++) step_cycle();
        div = DIV_W'(2);
        step_cycle();
        check("div_lower_vld", 64'(vld_o), 64'd1);

        // Randomised run against the reference.
        for (int it = 0; it < 150; it++) begin
            mode    = 2'($urandom_range(0, 3));
            rc_mode = 2'($urandom_range(0, 3));
            amp     = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 65535))
                                                  : W'($urandom_range(0, 300));
            step    = ($urandom_range(0, 4) == 0) ? W'($urandom_range(0, 65535))
                                                  : W'($urandom_range(0, 60));
            div     = DIV_W'($urandom_range(0, 4));
            for (int c = 0; c < int'($urandom_range(5, 40)); c++) begin
                en  = ($urandom_range(0, 9) != 0);
                rst = ($urandom_range(0, 199) != 0);
                step_cycle();
            end
            rst = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
